// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding, parameter defaults and counter widths for the alarm ring block
package alarm_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;

  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_SEC_DEF = 300;
  localparam int MAX_SNOOZE_DEF = 3;

  localparam int RING_CNT_W = 6;
  localparam int SNZ_CNT_W  = 9;

endpackage

// File: rtl/alarm_key_edge.sv
// rtl/alarm_key_edge.sv - one-bit key history register producing a single-cycle rising pulse
module alarm_key_edge (
  input  logic clk_1,
  input  logic ncr,
  input  logic key,
  output logic pulse
);

  logic key_q;

  always_ff @(posedge clk_1 or negedge ncr) begin
    if (!ncr) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key;
    end
  end

  // A held key yields exactly one pulse, on the first edge it is seen high.
  assign pulse = key & ~key_q;

endmodule

// File: rtl/alarm_ring.sv
// rtl/alarm_ring.sv - BCD alarm comparator and ring/snooze state machine driving buzzer and status
module alarm_ring
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
  input  logic       clk_1,
  input  logic       ncr,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  input  logic [7:0] AHour,
  input  logic [7:0] AMinute,
  input  logic       alarm_en,
  input  logic       key_stop,
  input  logic       key_snooze,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_left
);

  localparam logic [RING_CNT_W-1:0] RING_LAST  = RING_CNT_W'(RING_SEC - 1);
  localparam logic [SNZ_CNT_W-1:0]  SNZ_RELOAD = SNZ_CNT_W'(SNOOZE_SEC - 1);
  localparam logic [1:0]            LEFT_INIT  = 2'(MAX_SNOOZE);

  logic                  stop_p;
  logic                  snz_p;
  logic                  match;
  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [RING_CNT_W-1:0] ring_cnt;
  logic [RING_CNT_W-1:0] ring_cnt_n;
  logic [SNZ_CNT_W-1:0]  snz_cnt;
  logic [SNZ_CNT_W-1:0]  snz_cnt_n;
  logic [1:0]            left_n;

  alarm_key_edge u_stop_edge (
    .clk_1 (clk_1),
    .ncr   (ncr),
    .key   (key_stop),
    .pulse (stop_p)
  );

  alarm_key_edge u_snz_edge (
    .clk_1 (clk_1),
    .ncr   (ncr),
    .key   (key_snooze),
    .pulse (snz_p)
  );

  // BCD bytes compare directly; no binary conversion is needed for equality.
  assign match = alarm_en & (Hour == AHour) & (Minute == AMinute) & (Second == 8'h00);

  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
    snz_cnt_n  = snz_cnt;
    left_n     = snooze_left;
    case (state)
      ST_IDLE: begin
        if (match) begin
          state_n    = ST_RING;
          ring_cnt_n = '0;
          left_n     = LEFT_INIT;
        end
      end
      ST_RING: begin
        if (!alarm_en || stop_p) begin
          state_n = ST_IDLE;
        end else if (snz_p) begin
          if (snooze_left != 2'd0) begin
            state_n   = ST_SNOOZE;
            left_n    = snooze_left - 2'd1;
            snz_cnt_n = SNZ_RELOAD;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (ring_cnt == RING_LAST) begin
          state_n = ST_IDLE;
        end else begin
          ring_cnt_n = ring_cnt + 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (!alarm_en || stop_p) begin
          state_n = ST_IDLE;
        end else if (snz_cnt == '0) begin
          state_n    = ST_RING;
          ring_cnt_n = '0;
        end else begin
          snz_cnt_n = snz_cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state flop.
  always_ff @(posedge clk_1 or negedge ncr) begin
    if (!ncr) begin
      state       <= ST_IDLE;
      ring_cnt    <= '0;
      snz_cnt     <= '0;
      snooze_left <= LEFT_INIT;
      buzzer      <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
    end else begin
      state       <= state_n;
      ring_cnt    <= ring_cnt_n;
      snz_cnt     <= snz_cnt_n;
      snooze_left <= left_n;
      buzzer      <= (state_n == ST_RING) & ~ring_cnt_n[0];
      ringing     <= (state_n == ST_RING);
      snoozing    <= (state_n == ST_SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_ring.sv
// tb/tb_alarm_ring.sv - self-checking bench for alarm_ring: directed scenarios, vector table, randomized model comparison
module tb_alarm_ring;

  localparam int RS  = 60;
  localparam int SS  = 300;
  localparam int MS  = 3;
  localparam int DAY = 86400;

  logic       clk_1 = 1'b0;
  logic       ncr;
  logic [7:0] Hour, Minute, Second, AHour, AMinute;
  logic       alarm_en, key_stop, key_snooze;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_left;

  int checks = 0;
  int errors = 0;
  int t_sec;

  // Reference model: a phase name plus seconds elapsed in that phase.
  localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2;
  int m_mode, m_elapsed, m_left;
  bit m_prev_stop, m_prev_snz;

  alarm_ring #(.RING_SEC(RS), .SNOOZE_SEC(SS), .MAX_SNOOZE(MS)) dut (
    .clk_1(clk_1), .ncr(ncr), .Hour(Hour), .Minute(Minute), .Second(Second),
    .AHour(AHour), .AMinute(AMinute), .alarm_en(alarm_en), .key_stop(key_stop),
    .key_snooze(key_snooze), .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
    .snooze_left(snooze_left)
  );

  always #5 clk_1 = ~clk_1;

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    return (h[7:4] * 10 + h[3:0]) * 3600 + (m[7:4] * 10 + m[3:0]) * 60 + (s[7:4] * 10 + s[3:0]);
  endfunction

  task automatic drive_time();
    Hour   = bcd8(t_sec / 3600);
    Minute = bcd8((t_sec / 60) % 60);
    Second = bcd8(t_sec % 60);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_elapsed = 0; m_left = MS;
    m_prev_stop = 1'b0; m_prev_snz = 1'b0;
  endtask

  task automatic model_step();
    bit sp, zp, hit;
    sp = key_stop && !m_prev_stop;
    zp = key_snooze && !m_prev_snz;
    m_prev_stop = key_stop;
    m_prev_snz  = key_snooze;
    hit = alarm_en && from_bcd(Hour, Minute, Second) == from_bcd(AHour, AMinute, 8'h00)
          && Second == 8'h00;
    if (m_mode == M_IDLE) begin
      if (hit) begin m_mode = M_RING; m_elapsed = 0; m_left = MS; end
    end else if (m_mode == M_RING) begin
      if (!alarm_en || sp) m_mode = M_IDLE;
      else if (zp && m_left > 0) begin m_mode = M_SNOOZE; m_left--; m_elapsed = 0; end
      else if (zp) m_mode = M_IDLE;
      else if (m_elapsed + 1 >= RS) m_mode = M_IDLE;
      else m_elapsed++;
    end else begin
      if (!alarm_en || sp) m_mode = M_IDLE;
      else if (m_elapsed + 1 >= SS) begin m_mode = M_RING; m_elapsed = 0; end
      else m_elapsed++;
    end
  endtask

  task automatic check_all();
    chk("m_ringing", ringing, m_mode == M_RING);
    chk("m_snoozing", snoozing, m_mode == M_SNOOZE);
    chk("m_buzzer", buzzer, m_mode == M_RING && (m_elapsed % 2) == 0);
    chk("m_snooze_left", snooze_left, m_left);
  endtask

  task automatic tick();
    @(posedge clk_1);
    model_step();
    #1;
    check_all();
    t_sec = (t_sec + 1) % DAY;
    drive_time();
  endtask

  task automatic jump_before_alarm();
    t_sec = 7 * 3600 + 29 * 60 + 59;
    drive_time();
    tick();
    tick();
  endtask

  task automatic press_snooze();
    key_snooze = 1'b1;
    tick();
    key_snooze = 1'b0;
  endtask

  task automatic wait_ring();
    for (int i = 0; i < 400; i++) begin
      if (ringing) break;
      tick();
    end
    chk("wait_ring", ringing, 1);
  endtask

  typedef struct {
    logic [7:0] hr, mn, sc, ahr, amn;
    logic       en;
    logic       exp_ring;
  } vec_t;

  vec_t vecs[9];
  logic b[4];
  int   n;

  initial begin
    vecs[0] = '{8'h07, 8'h30, 8'h00, 8'h07, 8'h30, 1'b1, 1'b1};
    vecs[1] = '{8'h07, 8'h30, 8'h01, 8'h07, 8'h30, 1'b1, 1'b0};
    vecs[2] = '{8'h07, 8'h31, 8'h00, 8'h07, 8'h30, 1'b1, 1'b0};
    vecs[3] = '{8'h17, 8'h30, 8'h00, 8'h07, 8'h30, 1'b1, 1'b0};
    vecs[4] = '{8'h07, 8'h30, 8'h00, 8'h07, 8'h30, 1'b0, 1'b0};
    vecs[5] = '{8'h23, 8'h59, 8'h00, 8'h23, 8'h59, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h12, 8'h05, 8'h00, 8'h12, 8'h50, 1'b1, 1'b0};
    vecs[8] = '{8'h19, 8'h09, 8'h00, 8'h19, 8'h09, 1'b1, 1'b1};

    ncr = 1'b0; alarm_en = 1'b1; key_stop = 1'b0; key_snooze = 1'b0;
    AHour = 8'h07; AMinute = 8'h30;
    t_sec = 7 * 3600 + 29 * 60 + 58;
    drive_time();
    model_reset();
    #12;
    chk("rst_buzzer", buzzer, 0);
    chk("rst_ringing", ringing, 0);
    chk("rst_snoozing", snoozing, 0);
    chk("rst_snooze_left", snooze_left, MS);
    ncr = 1'b1;

    // Match at 07:30:00, beep pattern, self-timeout after 60 ringing cycles.
    tick();
    tick();
    chk("t1_pre_ring", ringing, 0);
    tick();
    chk("t1_ring", ringing, 1);
    b[0] = buzzer;
    n = 1;
    for (int i = 1; i < 100; i++) begin
      tick();
      if (i < 4) b[i] = buzzer;
      if (ringing) n++;
      else break;
    end
    chk("t1_beep0", b[0], 1);
    chk("t1_beep1", b[1], 0);
    chk("t1_beep2", b[2], 1);
    chk("t1_beep3", b[3], 0);
    chk("t1_ring_len", n, RS);
    chk("t1_idle", ringing, 0);

    // Held snooze key acts once; snooze lasts 300 cycles then rings with buzzer on.
    jump_before_alarm();
    chk("t2_ring", ringing, 1);
    for (int i = 0; i < 4; i++) tick();
    key_snooze = 1'b1;
    tick();
    chk("t2_snoozing", snoozing, 1);
    chk("t2_left", snooze_left, 2);
    n = 1;
    for (int i = 1; i < 400; i++) begin
      if (i == 4) key_snooze = 1'b0;
      tick();
      if (snoozing) n++;
      else break;
    end
    chk("t2_snz_len", n, SS);
    chk("t2_reringing", ringing, 1);
    chk("t2_rering_buzz", buzzer, 1);
    chk("t2_left_after", snooze_left, 2);

    // Exhaust snoozes; the fourth press behaves as stop.
    press_snooze();
    wait_ring();
    press_snooze();
    wait_ring();
    chk("t3_left0", snooze_left, 0);
    key_snooze = 1'b1;
    tick();
    key_snooze = 1'b0;
    chk("t3_stop_ring", ringing, 0);
    chk("t3_stop_snz", snoozing, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("t3_left_held", snooze_left, 0);
    jump_before_alarm();
    chk("t3_reload_ring", ringing, 1);
    chk("t3_reload_left", snooze_left, MS);

    // Stop and snooze on the same edge: stop wins, count unchanged.
    press_snooze();
    wait_ring();
    key_stop = 1'b1; key_snooze = 1'b1;
    tick();
    chk("t4_ring", ringing, 0);
    chk("t4_snz", snoozing, 0);
    chk("t4_left", snooze_left, 2);
    key_stop = 1'b0; key_snooze = 1'b0;
    tick();

    // Disarm during snooze, then no ring while disarmed.
    jump_before_alarm();
    press_snooze();
    chk("t5_snoozing", snoozing, 1);
    tick();
    tick();
    alarm_en = 1'b0;
    tick();
    chk("t5_snz_off", snoozing, 0);
    chk("t5_ring_off", ringing, 0);
    chk("t5_buzz_off", buzzer, 0);
    jump_before_alarm();
    chk("t5_disarmed", ringing, 0);
    alarm_en = 1'b1;
    tick();

    // Asynchronous reset mid-ring silences immediately; no retrigger afterwards.
    jump_before_alarm();
    tick();
    tick();
    chk("t6_buzz_on", buzzer, 1);
    #1;
    ncr = 1'b0;
    model_reset();
    #1;
    chk("t6_buzz", buzzer, 0);
    chk("t6_ring", ringing, 0);
    chk("t6_left", snooze_left, MS);
    #1;
    ncr = 1'b1;
    tick();
    tick();
    chk("t6_stay_idle", ringing, 0);

    // Comparator vector table.
    foreach (vecs[i]) begin
      t_sec = from_bcd(vecs[i].hr, vecs[i].mn, vecs[i].sc);
      drive_time();
      AHour = vecs[i].ahr; AMinute = vecs[i].amn; alarm_en = vecs[i].en;
      tick();
      chk("vec_ring", ringing, vecs[i].exp_ring);
      chk("vec_buzz", buzzer, vecs[i].exp_ring);
      if (ringing) begin
        key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        tick();
      end
    end
    alarm_en = 1'b1;

    // Randomized run against the model.
    AHour = 8'h07; AMinute = 8'h30;
    for (int i = 0; i < 3000; i++) begin
      int r, a;
      r = $urandom_range(0, 999);
      if (r < 6) begin
        a = from_bcd(AHour, AMinute, 8'h00);
        t_sec = (a + DAY - int'($urandom_range(0, 2))) % DAY;
        drive_time();
      end else if (r < 8) begin
        AHour = bcd8($urandom_range(0, 23));
        AMinute = bcd8($urandom_range(0, 59));
      end
      if ($urandom_range(0, 29) == 0) key_stop = ~key_stop;
      if ($urandom_range(0, 19) == 0) key_snooze = ~key_snooze;
      if (alarm_en ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 9) == 0))
        alarm_en = ~alarm_en;
      if ($urandom_range(0, 799) == 0) begin
        #1;
        ncr = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        ncr = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
